// File: rtl/serdes_tx_pkg.sv
// Shared state encoding and default word generators for the SERDES transmit framer.
package serdes_tx_pkg;

  localparam int unsigned MAX_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_TRAIN     = 3'd2,
    ST_SYNC      = 3'd3,
    ST_DATA      = 3'd4
  } state_t;

  // Alternating 1010... with bit 0 low, limited to the low `width` bits.
  function automatic logic [MAX_WIDTH-1:0] train_pattern(input int unsigned width);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++)
      p[i] = (i < width) && i[0];
    return p;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sync_word(input int unsigned width);
    logic [MAX_WIDTH-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++)
      w[i] = (i < width);
    return w;
  endfunction

endpackage

// File: rtl/serdes_tx_framer_if.sv
// Payload stream into the framer: data/valid from the source, ready back from the framer.
interface serdes_tx_framer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lock_wait_counter.sv
// Counts qualifying cycles up to LIMIT and holds there until cleared; done flags the limit.
module lock_wait_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc && !done)
      cnt <= cnt + CW'(1);
  end

  assign done = (cnt == CW'(LIMIT));

endmodule

// File: rtl/serdes_tx_framer.sv
// Transmit word generator for an output SERDES: lock wait, DPA training, one sync word,
// then payload or a free-running count.
module serdes_tx_framer
  import serdes_tx_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      LOCK_WAIT     = 255,
  parameter int unsigned      TRAIN_WORDS   = 64,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(train_pattern(WIDTH)),
  parameter logic [WIDTH-1:0] SYNC_WORD     = WIDTH'(sync_word(WIDTH)),
  parameter logic [WIDTH-1:0] FILL_WORD     = TRAIN_PATTERN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_n,
  input  logic              pll_lock,
  input  logic              retrain,
  input  logic              use_counter,
  serdes_tx_framer_if.slave payload,
  output logic [WIDTH-1:0]  tx_data,
  output logic              tx_valid,
  output logic              tx_oe,
  output logic              link_up
);

  localparam int unsigned TCW = $clog2(TRAIN_WORDS + 1);

  state_t           state, next_state;
  logic [TCW-1:0]   train_cnt, train_cnt_d;
  logic [WIDTH-1:0] count, count_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, oe_d, link_d;
  logic             lock_done, lock_clear, lock_inc;
  logic             ready, accept, train_last;

  assign ready          = (state == ST_DATA) && !use_counter;
  assign payload.s_ready = ready;
  assign accept         = ready && payload.s_valid;
  assign train_last     = (train_cnt == TCW'(TRAIN_WORDS - 1));

  assign lock_inc   = (state == ST_WAIT_LOCK) && pll_lock && !enable_n;
  assign lock_clear = (state != ST_WAIT_LOCK) || (next_state != ST_WAIT_LOCK) || !pll_lock;

  lock_wait_counter #(.LIMIT(LOCK_WAIT)) u_lock_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (lock_clear),
    .inc     (lock_inc),
    .done    (lock_done)
  );

  // Outputs are computed from next_state and registered with it, so each word lines
  // up with the state that produced it and appears the cycle after the decision.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (!enable_n) next_state = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_done) next_state = ST_TRAIN;
      ST_TRAIN:     if (train_last) next_state = ST_SYNC;
      ST_SYNC:      next_state = ST_DATA;
      ST_DATA:      if (retrain) next_state = ST_TRAIN;
      default:      next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE) begin
      if (enable_n)
        next_state = ST_IDLE;
      else if (!pll_lock)
        next_state = ST_WAIT_LOCK;
    end

    train_cnt_d = '0;
    if (state == ST_TRAIN && next_state == ST_TRAIN)
      train_cnt_d = train_cnt + TCW'(1);

    data_d  = '0;
    valid_d = 1'b0;
    oe_d    = 1'b0;
    link_d  = 1'b0;
    count_d = '0;
    case (next_state)
      ST_TRAIN: begin
        valid_d = 1'b1;
        oe_d    = 1'b1;
        data_d  = TRAIN_PATTERN;
      end
      ST_SYNC: begin
        valid_d = 1'b1;
        oe_d    = 1'b1;
        data_d  = SYNC_WORD;
      end
      ST_DATA: begin
        valid_d = 1'b1;
        oe_d    = 1'b1;
        link_d  = 1'b1;
        if (use_counter) begin
          data_d  = count;
          count_d = count + WIDTH'(1);
        end else begin
          count_d = count;
          data_d  = accept ? payload.s_data : FILL_WORD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      train_cnt <= '0;
      count     <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      tx_oe     <= 1'b0;
      link_up   <= 1'b0;
    end else begin
      state     <= next_state;
      train_cnt <= train_cnt_d;
      count     <= count_d;
      tx_data   <= data_d;
      tx_valid  <= valid_d;
      tx_oe     <= oe_d;
      link_up   <= link_d;
    end
  end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Directed bench for serdes_tx_framer: WIDTH 4, LOCK_WAIT 255, TRAIN_WORDS 64.
module tb_serdes_tx_framer;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] TP = 4'hA;
  localparam logic [W-1:0] SW = 4'hF;
  localparam logic [W-1:0] FW = 4'hA;

  logic         clk = 1'b0;
  logic         reset_n, enable_n, pll_lock, retrain, use_counter;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_oe, link_up;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic         uc;
    logic         valid;
    logic [W-1:0] data;
    logic         exp_ready;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  serdes_tx_framer_if #(.WIDTH(W)) pif ();

  serdes_tx_framer #(
    .WIDTH       (W),
    .LOCK_WAIT   (255),
    .TRAIN_WORDS (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_n    (enable_n),
    .pll_lock    (pll_lock),
    .retrain     (retrain),
    .use_counter (use_counter),
    .payload     (pif),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_oe       (tx_oe),
    .link_up     (link_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [W-1:0] d, input logic v,
                          input logic oe, input logic lk);
    chk({name, " tx_data"}, 32'(tx_data), 32'(d));
    chk({name, " tx_valid"}, 32'(tx_valid), 32'(v));
    chk({name, " tx_oe"}, 32'(tx_oe), 32'(oe));
    chk({name, " link_up"}, 32'(link_up), 32'(lk));
  endtask

  task automatic train_check(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      chk_outs($sformatf("train%0d", i), TP, 1'b1, 1'b1, 1'b0);
      chk("train s_ready", 32'(pif.s_ready), 32'(0));
      if (i == pulse_at) retrain = 1'b1;
      tick();
      retrain = 1'b0;
    end
  endtask

  task automatic count_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk_outs($sformatf("count%0d", i), W'(i), 1'b1, 1'b1, 1'b1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable_n = 1'b1; pll_lock = 1'b0; retrain = 1'b0;
    use_counter = 1'b0; pif.s_valid = 1'b0; pif.s_data = '0;

    //            uc    valid data   ready exp_data
    vecs[0] = '{1'b0, 1'b1, 4'h3, 1'b1, 4'h3};
    vecs[1] = '{1'b0, 1'b0, 4'h9, 1'b1, FW};
    vecs[2] = '{1'b0, 1'b1, 4'h5, 1'b1, 4'h5};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 1'b1, FW};
    vecs[4] = '{1'b0, 1'b1, 4'h7, 1'b1, 4'h7};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h2};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 1'b0, 4'h3};
    vecs[7] = '{1'b0, 1'b1, 4'hE, 1'b1, 4'hE};
    vecs[8] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h4};

    // Reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      enable_n    = 1'($urandom_range(0, 1));
      pll_lock    = 1'($urandom_range(0, 1));
      retrain     = 1'($urandom_range(0, 1));
      use_counter = 1'($urandom_range(0, 1));
      pif.s_valid = 1'($urandom_range(0, 1));
      pif.s_data  = W'($urandom);
      tick();
      chk_outs("reset_hold", '0, 1'b0, 1'b0, 1'b0);
      chk("reset_hold s_ready", 32'(pif.s_ready), 32'(0));
    end

    // Release with enable_n high: must stay idle even with lock present
    enable_n = 1'b1; pll_lock = 1'b1; retrain = 1'b0; use_counter = 1'b0;
    pif.s_valid = 1'b0; pif.s_data = '0;
    tick();
    reset_n = 1'b1;
    repeat (300) tick();
    chk_outs("idle_after_reset", '0, 1'b0, 1'b0, 1'b0);
    chk("idle s_ready", 32'(pif.s_ready), 32'(0));

    // Bring-up: first training word LOCK_WAIT+1 cycles after first lock cycle in WAIT_LOCK
    use_counter = 1'b1;
    enable_n = 1'b0;
    repeat (256) tick();
    chk("lock_wait early tx_oe", 32'(tx_oe), 32'(0));
    tick();
    train_check(64, -1);
    chk_outs("sync", SW, 1'b1, 1'b1, 1'b0);
    tick();
    count_check(17);

    // Payload / counter-hold vectors
    foreach (vecs[k]) begin
      use_counter = vecs[k].uc;
      pif.s_valid = vecs[k].valid;
      pif.s_data  = vecs[k].data;
      #1;
      chk($sformatf("vec%0d s_ready", k), 32'(pif.s_ready), 32'(vecs[k].exp_ready));
      tick();
      chk_outs($sformatf("vec%0d", k), vecs[k].exp_data, 1'b1, 1'b1, 1'b1);
    end
    pif.s_valid = 1'b0;

    // Retrain from DATA; a retrain pulse during TRAIN must not disturb the word count
    retrain = 1'b1;
    use_counter = 1'b0;
    tick();
    retrain = 1'b0;
    train_check(64, 10);
    use_counter = 1'b1;
    chk_outs("retrain sync", SW, 1'b1, 1'b1, 1'b0);
    tick();
    count_check(3);

    // Lock lost in DATA, then a one-cycle glitch at wait_cnt = 100
    pll_lock = 1'b0;
    tick();
    chk_outs("lock_drop", '0, 1'b0, 1'b0, 1'b0);
    pll_lock = 1'b1;
    repeat (100) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (255) tick();
    chk("glitch early tx_oe", 32'(tx_oe), 32'(0));
    tick();
    train_check(64, -1);
    chk_outs("glitch sync", SW, 1'b1, 1'b1, 1'b0);
    tick();
    count_check(2);

    // enable_n outranks retrain; restart latency shows the block went through IDLE
    enable_n = 1'b1;
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk_outs("prio_idle", '0, 1'b0, 1'b0, 1'b0);
    tick();
    enable_n = 1'b0;
    repeat (256) tick();
    chk("restart early tx_oe", 32'(tx_oe), 32'(0));
    tick();
    train_check(64, -1);
    chk_outs("pre_reset sync", SW, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-SYNC clears outputs without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("async_reset", '0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (256) tick();
    chk("post_reset early tx_oe", 32'(tx_oe), 32'(0));
    tick();
    chk_outs("post_reset train", TP, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
